serial_tx_piso: RTL

//   Parallel-in/serial-out framed transmitter; the sending end of the board's serial-in shift-register link.

---
 rtl/serial_pkg.sv | 15 +
 rtl/bit_timer.sv | 36 +++
 rtl/serial_tx_piso.sv | 120 ++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared line-level constants and transmitter state encoding for the serial shift-register link.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts clk_2 cycles within one bit and flags the last cycle of each period.
module bit_timer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk_2,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int TW = $clog2(BIT_CYCLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    logic [TW-1:0] tick_cnt_reg;
    logic [TW-1:0] tick_cnt_next;

    assign tick = (tick_cnt_reg == TICK_LAST);

    // Wraps at the terminal value so consecutive bits need no explicit restart.
    always_comb begin
        tick_cnt_next = tick_cnt_reg + TICK_ONE;
        if (clear || tick) begin
            tick_cnt_next = '0;
        end
    end

    always_ff @(posedge clk_2) begin
        if (!reset) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_next;
        end
    end

endmodule

// File: rtl/serial_tx_piso.sv
// Framed PISO transmitter: accepts a word on valid/ready and sends start bit, data LSB first, stop bit(s).
module serial_tx_piso
    import serial_pkg::*;
#(
    parameter int NBITS      = 4,
    parameter int STOP_BITS  = 1,
    parameter int BIT_CYCLES = 1
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic [NBITS-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(NBITS + 1);
    localparam int SW = $clog2(STOP_BITS + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS - 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [SW-1:0] STOP_ONE  = SW'(1);

    tx_state_t        state_reg, state_next;
    logic [NBITS-1:0] shift_reg, shift_next;
    logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [SW-1:0]    stop_cnt_reg, stop_cnt_next;
    logic             serial_out_reg, serial_out_next;
    logic             tick;
    logic             accept;

    bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .clk_2(clk_2),
        .reset(reset),
        .clear(state_reg == IDLE),
        .tick (tick)
    );

    assign load_ready = (state_reg == IDLE);
    assign busy       = (state_reg != IDLE);
    assign done       = (state_reg == STOP) && tick && (stop_cnt_reg == STOP_LAST);
    assign serial_out = serial_out_reg;
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        stop_cnt_next = stop_cnt_reg;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    shift_next    = data_in;
                    bit_cnt_next  = '0;
                    stop_cnt_next = '0;
                    state_next    = START;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next = shift_reg >> 1;
                    if (bit_cnt_reg == BIT_LAST) begin
                        bit_cnt_next = '0;
                        state_next   = STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BIT_ONE;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_cnt_reg == STOP_LAST) begin
                        stop_cnt_next = '0;
                        state_next    = IDLE;
                    end else begin
                        stop_cnt_next = stop_cnt_reg + STOP_ONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The line level is computed from the upcoming state so the register shows it in that state's first cycle.
    always_comb begin
        serial_out_next = LINE_IDLE;
        unique case (state_next)
            START:   serial_out_next = START_LEVEL;
            DATA:    serial_out_next = shift_next[0];
            STOP:    serial_out_next = STOP_LEVEL;
            default: serial_out_next = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (!reset) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            stop_cnt_reg   <= '0;
            serial_out_reg <= LINE_IDLE;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            bit_cnt_reg    <= bit_cnt_next;
            stop_cnt_reg   <= stop_cnt_next;
            serial_out_reg <= serial_out_next;
        end
    end

endmodule
